// File: rtl/tlp_demux_pkg.sv
// Shared TLP decode constants, DW0 field positions and demux FSM encoding.
package tlp_demux_pkg;

   localparam int unsigned DW0_W        = 32;
   localparam int unsigned DW0_FMT_MSB  = 31;
   localparam int unsigned DW0_FMT_LSB  = 29;
   localparam int unsigned DW0_TYPE_MSB = 28;
   localparam int unsigned DW0_TYPE_LSB = 24;

   localparam logic [2:0] FMT_3DW_ND = 3'b000;
   localparam logic [2:0] FMT_4DW_ND = 3'b001;
   localparam logic [2:0] FMT_3DW_D  = 3'b010;
   localparam logic [2:0] FMT_4DW_D  = 3'b011;
   localparam logic [4:0] TYPE_MEM   = 5'b00000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_DROP = 2'd3
   } state_t;

   // Maps DW0 to its destination: memory read, memory write or discard.
   function automatic state_t decode_dw0(input logic [DW0_W-1:0] dw0);
      logic [2:0] fmt;
      logic [4:0] typ;
      fmt        = dw0[DW0_FMT_MSB:DW0_FMT_LSB];
      typ        = dw0[DW0_TYPE_MSB:DW0_TYPE_LSB];
      decode_dw0 = ST_DROP;
      if (typ == TYPE_MEM) begin
         if (fmt == FMT_3DW_ND || fmt == FMT_4DW_ND)
            decode_dw0 = ST_RD;
         else if (fmt == FMT_3DW_D || fmt == FMT_4DW_D)
            decode_dw0 = ST_WR;
      end
   endfunction

endpackage

// File: rtl/tlp_out_reg.sv
// One-entry valid/ready register slice for a single demux output port.
// Ports: clk, rst_n (async, active-high), i_load + beat fields in,
//        i_ready from the sink, registered beat out, o_free_c = slot can load.
module tlp_out_reg #(
   parameter int unsigned DATA_W = 256,
   parameter int unsigned HDR_W  = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic [HDR_W-1:0]  i_hdr,
   input  logic              i_sop,
   input  logic              i_eop,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [HDR_W-1:0]  o_hdr,
   output logic              o_sop,
   output logic              o_eop,
   output logic              o_valid,
   output logic              o_free_c
);

   logic [DATA_W-1:0] r_data;
   logic [HDR_W-1:0]  r_hdr;
   logic              r_sop;
   logic              r_eop;
   logic              r_valid;

   // Load wins over drain so a simultaneous take-and-refill has no bubble.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_data  <= '0;
         r_hdr   <= '0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_hdr   <= i_hdr;
         r_sop   <= i_sop;
         r_eop   <= i_eop;
         r_valid <= 1'b1;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data   = r_data;
   assign o_hdr    = r_hdr;
   assign o_sop    = r_sop;
   assign o_eop    = r_eop;
   assign o_valid  = r_valid;
   assign o_free_c = ~r_valid | i_ready;

endmodule

// File: rtl/tlp_demux.sv
// Routes incoming TLP beats to a memory-read or memory-write output port,
// discarding illegal packets and stray non-sop beats.
// Ports: clk, rst_n (async, active-high), enable (acceptance gate),
//        in_* input beat with in_ready, r_out_* read port, w_out_* write port.
module tlp_demux
   import tlp_demux_pkg::*;
#(
   parameter int unsigned PORTS          = 2,
   parameter int unsigned DOUBLE_WORD    = 32,
   parameter int unsigned HEADER_SIZE    = 4 * DOUBLE_WORD,
   parameter int unsigned TLP_DATA_WIDTH = 8 * DOUBLE_WORD
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic [TLP_DATA_WIDTH-1:0] in_data,
   input  logic [HEADER_SIZE-1:0]    in_hdr,
   input  logic                      in_sop,
   input  logic                      in_eop,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [TLP_DATA_WIDTH-1:0] r_out_data,
   output logic [HEADER_SIZE-1:0]    r_out_hdr,
   output logic                      r_out_sop,
   output logic                      r_out_eop,
   output logic                      r_out_valid,
   input  logic                      r_out_ready,
   output logic [TLP_DATA_WIDTH-1:0] w_out_data,
   output logic [HEADER_SIZE-1:0]    w_out_hdr,
   output logic                      w_out_sop,
   output logic                      w_out_eop,
   output logic                      w_out_valid,
   input  logic                      w_out_ready
);

   logic [DOUBLE_WORD-1:0] w_dw0;
   state_t                 w_sop_route;
   state_t                 w_route;
   state_t                 r_state;
   logic                   w_free_r;
   logic                   w_free_w;
   logic [PORTS-1:0]       w_port_free;
   logic                   w_dest_free;
   logic                   w_accept;
   logic                   w_load_r;
   logic                   w_load_w;

   assign w_dw0       = in_hdr[HEADER_SIZE-1 -: DOUBLE_WORD];
   assign w_sop_route = decode_dw0(DW0_W'(w_dw0));
   assign w_port_free = {w_free_w, w_free_r};

   // A sop always re-decodes; continuation beats follow the latched route,
   // and continuation beats with no open packet are discarded.
   always_comb begin
      w_route = ST_DROP;
      if (in_sop)
         w_route = w_sop_route;
      else if (r_state != ST_IDLE)
         w_route = r_state;
   end

   // Discarded beats never wait on an output port.
   always_comb begin
      w_dest_free = 1'b1;
      case (w_route)
         ST_RD:   w_dest_free = w_port_free[0];
         ST_WR:   w_dest_free = w_port_free[1];
         default: w_dest_free = 1'b1;
      endcase
   end

   assign in_ready = enable & ~rst_n & w_dest_free;
   assign w_accept = in_valid & in_ready;
   assign w_load_r = w_accept & (w_route == ST_RD);
   assign w_load_w = w_accept & (w_route == ST_WR);

   // Packet tracker: only accepted beats move it, so enable=0 holds state.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state <= ST_IDLE;
      end else if (w_accept) begin
         if (in_sop)
            r_state <= in_eop ? ST_IDLE : w_sop_route;
         else if (in_eop)
            r_state <= ST_IDLE;
      end
   end

   tlp_out_reg #(
      .DATA_W (TLP_DATA_WIDTH),
      .HDR_W  (HEADER_SIZE)
   ) u_rd_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load_r),
      .i_data   (in_data),
      .i_hdr    (in_hdr),
      .i_sop    (in_sop),
      .i_eop    (in_eop),
      .i_ready  (r_out_ready),
      .o_data   (r_out_data),
      .o_hdr    (r_out_hdr),
      .o_sop    (r_out_sop),
      .o_eop    (r_out_eop),
      .o_valid  (r_out_valid),
      .o_free_c (w_free_r)
   );

   tlp_out_reg #(
      .DATA_W (TLP_DATA_WIDTH),
      .HDR_W  (HEADER_SIZE)
   ) u_wr_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load_w),
      .i_data   (in_data),
      .i_hdr    (in_hdr),
      .i_sop    (in_sop),
      .i_eop    (in_eop),
      .i_ready  (w_out_ready),
      .o_data   (w_out_data),
      .o_hdr    (w_out_hdr),
      .o_sop    (w_out_sop),
      .o_eop    (w_out_eop),
      .o_valid  (w_out_valid),
      .o_free_c (w_free_w)
   );

endmodule

// File: tb/tb_tlp_demux.sv
// Bench for tlp_demux: directed scenarios followed by random traffic from a
// tlp_tx-style generator, checked against a packet-level reference model.
module tb_tlp_demux;
   import tlp_demux_pkg::*;

   localparam int unsigned DW = 256;
   localparam int unsigned HW = 128;
   localparam int D_RD   = 1;
   localparam int D_WR   = 2;
   localparam int D_DROP = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic [DW-1:0] in_data;
   logic [HW-1:0] in_hdr;
   logic          in_sop, in_eop, in_valid, in_ready;
   logic [DW-1:0] r_out_data, w_out_data;
   logic [HW-1:0] r_out_hdr, w_out_hdr;
   logic          r_out_sop, r_out_eop, r_out_valid, r_out_ready;
   logic          w_out_sop, w_out_eop, w_out_valid, w_out_ready;

   always #5 clk = ~clk;

   tlp_demux dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .in_data     (in_data),
      .in_hdr      (in_hdr),
      .in_sop      (in_sop),
      .in_eop      (in_eop),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .r_out_data  (r_out_data),
      .r_out_hdr   (r_out_hdr),
      .r_out_sop   (r_out_sop),
      .r_out_eop   (r_out_eop),
      .r_out_valid (r_out_valid),
      .r_out_ready (r_out_ready),
      .w_out_data  (w_out_data),
      .w_out_hdr   (w_out_hdr),
      .w_out_sop   (w_out_sop),
      .w_out_eop   (w_out_eop),
      .w_out_valid (w_out_valid),
      .w_out_ready (w_out_ready)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic [HW-1:0] hdr;
      logic          sop;
      logic          eop;
   } beat_t;

   // Reference model: beats waiting in each port, plus the open packet's route.
   beat_t q_r[$];
   beat_t q_w[$];
   int    m_dest;
   bit    m_in_pkt;
   bit    last_acc;
   bit    tog_w;
   int    n_assert;
   int    n_fail;
   logic [HW-1:0] h;

   function automatic int classify(input logic [HW-1:0] hd);
      int f;
      int t;
      f = int'(hd[127:125]);
      t = int'(hd[124:120]);
      if (t == 0 && f <= 1) return D_RD;
      if (t == 0 && (f == 2 || f == 3)) return D_WR;
      return D_DROP;
   endfunction

   function automatic int cur_target();
      if (in_sop) return classify(in_hdr);
      if (m_in_pkt) return m_dest;
      return D_DROP;
   endfunction

   function automatic logic [HW-1:0] mk_hdr(input logic [31:0] dw0);
      return {dw0, $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks the DUT against the model, then advances the model by one edge.
   task automatic check_cycle();
      int    tgt;
      logic  free;
      logic  exp_ir;
      logic  acc;
      beat_t b;
      tgt = cur_target();
      if (tgt == D_RD)      free = (q_r.size() == 0) || r_out_ready;
      else if (tgt == D_WR) free = (q_w.size() == 0) || w_out_ready;
      else                  free = 1'b1;
      exp_ir = enable & ~rst_n & free;
      chk("in_ready", in_ready, exp_ir);
      chk("r_valid", r_out_valid, q_r.size() != 0);
      if (q_r.size() != 0) begin
         chk("r_data", r_out_data, q_r[0].data);
         chk("r_hdr", r_out_hdr, q_r[0].hdr);
         chk("r_sop", r_out_sop, q_r[0].sop);
         chk("r_eop", r_out_eop, q_r[0].eop);
      end
      chk("w_valid", w_out_valid, q_w.size() != 0);
      if (q_w.size() != 0) begin
         chk("w_data", w_out_data, q_w[0].data);
         chk("w_hdr", w_out_hdr, q_w[0].hdr);
         chk("w_sop", w_out_sop, q_w[0].sop);
         chk("w_eop", w_out_eop, q_w[0].eop);
      end
      acc      = in_valid & exp_ir;
      last_acc = acc;
      if (q_r.size() != 0 && r_out_ready) void'(q_r.pop_front());
      if (q_w.size() != 0 && w_out_ready) void'(q_w.pop_front());
      if (acc) begin
         b.data = in_data;
         b.hdr  = in_hdr;
         b.sop  = in_sop;
         b.eop  = in_eop;
         if (tgt == D_RD) q_r.push_back(b);
         else if (tgt == D_WR) q_w.push_back(b);
         if (in_sop) begin
            m_dest   = tgt;
            m_in_pkt = !in_eop;
         end else if (m_in_pkt && in_eop) begin
            m_in_pkt = 1'b0;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
      if (tog_w) w_out_ready = ~w_out_ready;
   endtask

   // Presents one beat and waits (bounded) until it is accepted.
   task automatic send(input logic [HW-1:0] hd, input logic [DW-1:0] d,
                       input logic s, input logic e);
      in_valid = 1'b1;
      in_hdr   = hd;
      in_data  = d;
      in_sop   = s;
      in_eop   = e;
      for (int k = 0; k < 50; k++) begin
         step();
         if (last_acc) break;
      end
      chk("beat_accepted", last_acc, 1'b1);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
   endtask

   task automatic model_reset();
      q_r.delete();
      q_w.delete();
      m_in_pkt = 1'b0;
      last_acc = 1'b0;
   endtask

   // tlp_tx: a fresh random MRd, MWr or illegal beat.
   task automatic tx_new_beat();
      logic [31:0] dw0;
      int          kind;
      dw0  = $urandom();
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
         dw0[31:29] = 3'($urandom_range(0, 1));
         dw0[28:24] = 5'd0;
      end else if (kind == 1) begin
         dw0[31:29] = 3'($urandom_range(2, 3));
         dw0[28:24] = 5'd0;
      end else if ($urandom_range(0, 1) == 0) begin
         dw0[28:24] = 5'($urandom_range(1, 31));
      end else begin
         dw0[31:29] = 3'($urandom_range(4, 7));
         dw0[28:24] = 5'd0;
      end
      in_hdr   = mk_hdr(dw0);
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
      in_sop   = ($urandom_range(0, 2) == 0);
      in_eop   = ($urandom_range(0, 2) == 0);
      in_valid = ($urandom_range(0, 7) != 0);
   endtask

   initial begin
      n_assert    = 0;
      n_fail      = 0;
      tog_w       = 1'b0;
      m_dest      = D_DROP;
      model_reset();
      rst_n       = 1'b0;
      enable      = 1'b1;
      in_data     = '0;
      in_hdr      = '0;
      in_sop      = 1'b0;
      in_eop      = 1'b0;
      in_valid    = 1'b0;
      r_out_ready = 1'b1;
      w_out_ready = 1'b1;
      #1 rst_n = 1'b1;
      #1;

      // Reset state
      chk("rst_r_valid", r_out_valid, 1'b0);
      chk("rst_w_valid", w_out_valid, 1'b0);
      chk("rst_r_sop", r_out_sop, 1'b0);
      chk("rst_r_eop", r_out_eop, 1'b0);
      chk("rst_w_sop", w_out_sop, 1'b0);
      chk("rst_w_eop", w_out_eop, 1'b0);
      chk("rst_r_data", r_out_data, '0);
      chk("rst_w_data", w_out_data, '0);
      chk("rst_r_hdr", r_out_hdr, '0);
      chk("rst_w_hdr", w_out_hdr, '0);
      chk("rst_in_ready", in_ready, 1'b0);
      step();
      step();
      rst_n = 1'b0;

      // Single-beat MRd
      h = mk_hdr(32'h0000_0001);
      send(h, 256'hAB, 1'b1, 1'b1);
      chk("mrd_r_valid", r_out_valid, 1'b1);
      chk("mrd_r_hdr", r_out_hdr, h);
      chk("mrd_w_idle", w_out_valid, 1'b0);
      idle();
      step();

      // Three-beat MWr
      h = mk_hdr(32'h6000_0004);
      send(h, 256'h01, 1'b1, 1'b0);
      chk("mwr_b1_data", w_out_data, 256'h01);
      chk("mwr_b1_sop", w_out_sop, 1'b1);
      send(h, 256'h02, 1'b0, 1'b0);
      chk("mwr_b2_data", w_out_data, 256'h02);
      send(h, 256'h03, 1'b0, 1'b1);
      chk("mwr_b3_data", w_out_data, 256'h03);
      chk("mwr_b3_eop", w_out_eop, 1'b1);
      chk("mwr_r_idle", r_out_valid, 1'b0);
      idle();
      repeat (2) step();

      // Illegal CplD, then a stray continuation beat that must be discarded
      h = mk_hdr(32'h4A00_0001);
      send(h, 256'h11, 1'b1, 1'b0);
      send(h, 256'h12, 1'b0, 1'b1);
      idle();
      step();
      chk("drop_fsm_idle", 256'(dut.r_state), 256'(ST_IDLE));
      chk("drop_r_idle", r_out_valid, 1'b0);
      chk("drop_w_idle", w_out_valid, 1'b0);
      send(mk_hdr(32'h6000_0001), 256'h13, 1'b0, 1'b1);
      idle();
      step();
      chk("stray_w_idle", w_out_valid, 1'b0);

      // Four-beat MWr with w_out_ready toggling every cycle
      w_out_ready = 1'b0;
      tog_w       = 1'b1;
      h = mk_hdr(32'h4000_0008);
      for (int i = 0; i < 4; i++)
         send(h, DW'(32'h100 + i), (i == 0), (i == 3));
      idle();
      repeat (6) step();
      tog_w       = 1'b0;
      w_out_ready = 1'b1;
      repeat (2) step();

      // enable low for five cycles mid-packet
      h = mk_hdr(32'h6000_0003);
      send(h, 256'h21, 1'b1, 1'b0);
      in_data = 256'h22;
      in_sop  = 1'b0;
      enable  = 1'b0;
      repeat (5) begin
         step();
         chk("en_off_in_ready", in_ready, 1'b0);
      end
      enable = 1'b1;
      send(h, 256'h22, 1'b0, 1'b0);
      send(h, 256'h23, 1'b0, 1'b1);
      idle();
      repeat (2) step();

      // Reset mid-packet with a beat held in the write port
      w_out_ready = 1'b0;
      h = mk_hdr(32'h6000_0002);
      send(h, 256'h31, 1'b1, 1'b0);
      chk("pre_rst_w_valid", w_out_valid, 1'b1);
      in_data = 256'h32;
      in_sop  = 1'b0;
      rst_n   = 1'b1;
      #1;
      model_reset();
      chk("mid_rst_r_valid", r_out_valid, 1'b0);
      chk("mid_rst_w_valid", w_out_valid, 1'b0);
      chk("mid_rst_in_ready", in_ready, 1'b0);
      step();
      rst_n       = 1'b0;
      w_out_ready = 1'b1;
      send(h, 256'h33, 1'b0, 1'b1);
      h = mk_hdr(32'h2000_0001);
      send(h, 256'h34, 1'b1, 1'b1);
      chk("post_rst_r_valid", r_out_valid, 1'b1);
      chk("post_rst_r_hdr", r_out_hdr, h);
      chk("post_rst_w_idle", w_out_valid, 1'b0);
      idle();
      step();

      // Random traffic
      last_acc = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (!in_valid || last_acc) tx_new_beat();
         r_out_ready = ($urandom_range(0, 3) != 0);
         w_out_ready = ($urandom_range(0, 3) != 0);
         enable      = ($urandom_range(0, 15) != 0);
         step();
      end
      idle();
      enable      = 1'b1;
      r_out_ready = 1'b1;
      w_out_ready = 1'b1;
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/tlp_demux.md
TLP_DEMUX -- requirements
Module: tlp_demux

Interface
REQ-001 SHALL have parameter PORTS, default 2, number of output ports; only 2 is supported.
REQ-002 SHALL have parameter DOUBLE_WORD, default 32, DW width in bits.
REQ-003 SHALL have parameter HEADER_SIZE, default 4*DOUBLE_WORD (128), header width.
REQ-004 SHALL have parameter TLP_DATA_WIDTH, default 8*DOUBLE_WORD (256), payload beat width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous and active-high (asserted = 1).
REQ-007 SHALL have inputs in_data [TLP_DATA_WIDTH], in_hdr [HEADER_SIZE], in_sop, in_eop and in_valid, 1 bit each except as sized: the input TLP beat.
REQ-008 SHALL have output in_ready, 1: input beat accepted when in_valid & in_ready.
REQ-009 SHALL have outputs r_out_data, r_out_hdr, r_out_sop, r_out_eop and r_out_valid, plus input r_out_ready: the memory-read port.
REQ-010 SHALL have outputs w_out_data, w_out_hdr, w_out_sop, w_out_eop and w_out_valid, plus input w_out_ready: the memory-write port.
REQ-011 SHALL have input enable, 1: acceptance gate.

Function
REQ-012 DW0 = in_hdr[127:96]; fmt = DW0[31:29], type = DW0[28:24].
REQ-013 Decode: type 00000 with fmt 000/001 = MRd, routed to r_out; type 00000 with fmt 010/011 = MWr, routed to w_out; anything else = illegal.
REQ-014 Route decided combinationally on the accepted sop beat and latched; non-sop beats use the latched route.
REQ-015 FSM states: IDLE, RD, WR, DROP.
- Accepted sop with !eop goes to RD, WR or DROP per decode.
- Accepted sop&eop stays IDLE.
- Accepted eop in RD/WR/DROP goes to IDLE.
REQ-016 Accepted sop in a non-IDLE state SHALL start a new packet (re-decode); the previous packet is truncated without eop.
REQ-017 Accepted non-sop beat in IDLE SHALL be discarded.
REQ-018 Each output port SHALL hold a one-entry register (data, hdr, sop, eop, valid); a beat routed to it appears on the next cycle (latency 1).
REQ-019 out_valid SHALL stay high with data stable until out_ready; it clears on out_ready & !new load.
REQ-020 Simultaneous drain and load on one port SHALL give back-to-back beats without a bubble.
REQ-021 in_ready = enable & !reset & (destination free), where destination free = (!out_valid | out_ready) of the target port. DROP/illegal and discarded beats need only enable.
REQ-022 enable = 0 SHALL drop in_ready to 0; output registers still drain; FSM state is held.
REQ-023 Fields are copied unmodified; MRd payload is passed as-is and treated as don't-care.
REQ-024 The two ports are independent; a stall on one blocks input only while the input targets that port.

Reset
REQ-025 While rst_n = 1, and immediately on assertion:
- FSM goes to IDLE.
- All *_valid, *_sop, *_eop = 0; *_data and *_hdr = 0.
- in_ready = 0.
REQ-026 Reset mid-packet SHALL abandon the packet; after release the first accepted beat must be a sop.

Structure
REQ-027 A shared package SHALL hold the fmt/type constants (FMT_3DW_ND, FMT_4DW_ND, FMT_3DW_D, FMT_4DW_D, TYPE_MEM), the DW0 bit positions and the FSM state encoding.
REQ-028 A sub-module tlp_out_reg (one-entry valid/ready register slice) SHALL be instantiated once per port.
REQ-029 tlp_tx is the bench stimulus generator, not part of the RTL. Each time in_ready = 1 it presents a new random beat: MRd, MWr or illegal.

Verification
REQ-030 MRd single beat, DW0 = 0x00000001, sop = eop = 1, r_out_ready = 1 -> r_out_valid = 1 next cycle with identical hdr; w_out_valid stays 0.
REQ-031 MWr 3 beats, DW0 = 0x60000004, data 0x..01/02/03 -> w_out shows beats 01, 02, 03 in order, sop on the first, eop on the third; r_out idle.
REQ-032 Illegal CplD, DW0 = 0x4A000001, 2 beats -> in_ready = 1 for both; no valid on either port; FSM returns to IDLE.
REQ-033 w_out_ready toggling 0/1 each cycle during a 4-beat MWr -> each beat held stable until taken; no loss or duplication; in_ready low while the port is full.
REQ-034 enable = 0 for 5 cycles mid-packet -> in_ready = 0 during those cycles; the packet completes correctly after enable returns to 1.
REQ-035 rst_n pulsed mid-packet -> all valids = 0 at once; the next MRd sop routes correctly.
